// File: rtl/spi_deserializer_fifo_pkg.sv
// Shared types and width helpers for the serial-to-parallel receive path.
package spi_deser_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/spi_deserializer_fifo_if.sv
// Bus bundle for the deserializer: serial input side plus valid/ack word output side.
// Handshake: a word transfers on a cycle where parallel_valid && parallel_ack; ack while empty is ignored.
interface spi_deserializer_fifo_if #(
    parameter int PARALLEL_WIDTH = 8,
    parameter int FIFO_DEPTH     = 4
);
    import spi_deser_pkg::*;

    localparam int CW = count_width(FIFO_DEPTH);

    logic                      serial_ready;
    logic                      serial_in;
    logic                      frame_start;
    logic                      parallel_ack;
    logic                      parallel_valid;
    logic [PARALLEL_WIDTH-1:0] parallel_out;
    logic [CW-1:0]             fifo_count;
    logic                      overrun;
    logic                      frame_error;
    state_t                    dbg_state;

    modport master (
        output serial_ready, serial_in, frame_start, parallel_ack,
        input  parallel_valid, parallel_out, fifo_count, overrun, frame_error, dbg_state
    );

    modport slave (
        input  serial_ready, serial_in, frame_start, parallel_ack,
        output parallel_valid, parallel_out, fifo_count, overrun, frame_error, dbg_state
    );

endinterface

// File: rtl/spi_deserializer_fifo_sync_fifo.sv
// Word FIFO; a push while full succeeds only when a pop happens in the same cycle.
module sync_fifo
    import spi_deser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_data,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_data,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [count_width(DEPTH)-1:0]  o_count
);
    localparam int CW = count_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/spi_deserializer_fifo.sv
// Serial bit assembler feeding a word FIFO; frame_start re-aligns to bit 0 of a new word.
module spi_deserializer_fifo
    import spi_deser_pkg::*;
#(
    parameter int PARALLEL_WIDTH = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter bit MSB_FIRST      = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    spi_deserializer_fifo_if.slave   bus
);
    localparam int W  = PARALLEL_WIDTH;
    localparam int BW = $clog2(W);
    localparam int CW = count_width(FIFO_DEPTH);

    state_t          r_state;
    logic [BW-1:0]   r_bit_cnt;
    logic [W-1:0]    r_shift;
    logic            r_overrun;
    logic            r_frame_error;

    logic            w_resync;
    logic            w_last;
    logic [W-1:0]    w_base;
    logic [W-1:0]    w_assembled;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic [W-1:0]    w_head;
    logic [CW-1:0]   w_count;

    // frame_start on the final bit of a word still wins: the partial word is dropped.
    assign w_resync = bus.serial_ready && bus.frame_start && (r_state == S_SHIFT);
    assign w_last   = bus.serial_ready && !w_resync && (r_bit_cnt == BW'(W - 1));
    assign w_base   = w_resync ? '0 : r_shift;
    assign w_pop    = bus.parallel_ack && !w_empty;

    always_comb begin
        w_assembled = '0;
        if (MSB_FIRST) w_assembled = {w_base[W-2:0], bus.serial_in};
        else           w_assembled = {bus.serial_in, w_base[W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_overrun     <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_overrun     <= w_last && w_full && !w_pop;
            r_frame_error <= w_resync;
            if (bus.serial_ready) begin
                r_shift <= w_assembled;
                if (w_resync) begin
                    r_bit_cnt <= BW'(1);
                    r_state   <= S_SHIFT;
                end else if (w_last) begin
                    r_bit_cnt <= '0;
                    r_state   <= S_IDLE;
                end else begin
                    r_bit_cnt <= r_bit_cnt + BW'(1);
                    r_state   <= S_SHIFT;
                end
            end
        end
    end

    sync_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_last),
        .i_data  (w_assembled),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.parallel_valid = !w_empty;
    assign bus.parallel_out   = w_head;
    assign bus.fifo_count     = w_count;
    assign bus.overrun        = r_overrun;
    assign bus.frame_error    = r_frame_error;
    assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_spi_deserializer_fifo.sv
// Bench for spi_deserializer_fifo: MSB-first and LSB-first instances share one stimulus stream.
module tb_spi_deserializer_fifo;
    import spi_deser_pkg::*;

    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic started = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    spi_deserializer_fifo_if #(.PARALLEL_WIDTH(W), .FIFO_DEPTH(D)) if_m ();
    spi_deserializer_fifo_if #(.PARALLEL_WIDTH(W), .FIFO_DEPTH(D)) if_l ();

    spi_deserializer_fifo #(.PARALLEL_WIDTH(W), .FIFO_DEPTH(D), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .bus(if_m));
    spi_deserializer_fifo #(.PARALLEL_WIDTH(W), .FIFO_DEPTH(D), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .bus(if_l));

    assign if_l.serial_ready = if_m.serial_ready;
    assign if_l.serial_in    = if_m.serial_in;
    assign if_l.frame_start  = if_m.frame_start;
    assign if_l.parallel_ack = if_m.parallel_ack;

    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic         bits_q[$];
    logic [W-1:0] qm[$];
    logic [W-1:0] ql[$];
    logic         mod_ov = 1'b0;
    logic         mod_fe = 1'b0;

    always @(posedge clk) begin
        int occ;
        logic pop, push;
        logic [W-1:0] wm, wl;
        if (reset) begin
            bits_q.delete(); qm.delete(); ql.delete();
            mod_ov = 1'b0; mod_fe = 1'b0;
            started = 1'b1;
        end else begin
            occ = qm.size();
            pop = if_m.parallel_ack && (occ > 0);
            push = 1'b0; mod_ov = 1'b0; mod_fe = 1'b0;
            wm = '0; wl = '0;
            if (if_m.serial_ready) begin
                if (if_m.frame_start && bits_q.size() > 0) begin
                    mod_fe = 1'b1;
                    bits_q.delete();
                end
                bits_q.push_back(if_m.serial_in);
                if (bits_q.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        wm[W-1-i] = bits_q[i];
                        wl[i]     = bits_q[i];
                    end
                    push = 1'b1;
                    bits_q.delete();
                end
            end
            if (pop) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (push) begin
                if (occ < D || pop) begin
                    qm.push_back(wm);
                    ql.push_back(wl);
                end else begin
                    mod_ov = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("m_valid", 32'(if_m.parallel_valid), 32'(qm.size() > 0));
            chk("m_out",   32'(if_m.parallel_out),   32'(qm.size() > 0 ? qm[0] : '0));
            chk("m_count", 32'(if_m.fifo_count),     32'(qm.size()));
            chk("m_ovr",   32'(if_m.overrun),        32'(mod_ov));
            chk("m_ferr",  32'(if_m.frame_error),    32'(mod_fe));
            chk("m_state", 32'(if_m.dbg_state),      32'(bits_q.size() > 0 ? S_SHIFT : S_IDLE));
            chk("l_valid", 32'(if_l.parallel_valid), 32'(ql.size() > 0));
            chk("l_out",   32'(if_l.parallel_out),   32'(ql.size() > 0 ? ql[0] : '0));
            chk("l_count", 32'(if_l.fifo_count),     32'(ql.size()));
            chk("l_ovr",   32'(if_l.overrun),        32'(mod_ov));
            chk("l_ferr",  32'(if_l.frame_error),    32'(mod_fe));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic b, input logic fs, input logic ack_now);
        if_m.serial_ready = 1'b1;
        if_m.serial_in    = b;
        if_m.frame_start  = fs;
        if_m.parallel_ack = ack_now;
        tick();
        if_m.serial_ready = 1'b0;
        if_m.frame_start  = 1'b0;
        if_m.parallel_ack = 1'b0;
    endtask

    // Bits go out word[7] first, so the MSB-first instance reassembles the same value.
    task automatic send_word(input logic [W-1:0] w, input logic fs_first, input logic ack_last);
        for (int i = W - 1; i >= 0; i--)
            send_bit(w[i], fs_first && (i == W - 1), ack_last && (i == 0));
    endtask

    task automatic drain_one(input logic [W-1:0] exp);
        chk("drain_head", 32'(if_m.parallel_out), 32'(exp));
        if_m.parallel_ack = 1'b1;
        tick();
        if_m.parallel_ack = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [W-1:0] pat;
        if_m.serial_ready = 1'b0;
        if_m.serial_in    = 1'b0;
        if_m.frame_start  = 1'b0;
        if_m.parallel_ack = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        chk("reset_valid", 32'(if_m.parallel_valid), 32'd0);
        chk("reset_count", 32'(if_m.fifo_count), 32'd0);
        reset = 1'b0;

        // continuous 0,1,0,1,...
        pat = 8'h55;
        for (int i = W - 1; i >= 1; i--) send_bit(pat[i], 1'b0, 1'b0);
        chk("t1_not_yet", 32'(if_m.parallel_valid), 32'd0);
        send_bit(pat[0], 1'b0, 1'b0);
        chk("t1_valid", 32'(if_m.parallel_valid), 32'd1);
        chk("t1_msb", 32'(if_m.parallel_out), 32'h55);
        chk("t1_lsb", 32'(if_l.parallel_out), 32'hAA);
        chk("t1_count", 32'(if_m.fifo_count), 32'd1);
        drain_one(8'h55);
        chk("t1_empty_out", 32'(if_m.parallel_out), 32'd0);

        // same bits with 1..3 idle cycles between them
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(pat[i], 1'b0, 1'b0);
            repeat ((i % 3) + 1) tick();
        end
        chk("t2_msb", 32'(if_m.parallel_out), 32'h55);
        chk("t2_count", 32'(if_m.fifo_count), 32'd1);
        drain_one(8'h55);

        // overflow with no ack
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        send_word(8'h33, 1'b0, 1'b0);
        send_word(8'h44, 1'b0, 1'b0);
        chk("t3_full", 32'(if_m.fifo_count), 32'd4);
        chk("t3_no_ovr", 32'(if_m.overrun), 32'd0);
        send_word(8'h55, 1'b0, 1'b0);
        chk("t3_ovr", 32'(if_m.overrun), 32'd1);
        chk("t3_count", 32'(if_m.fifo_count), 32'd4);
        tick();
        chk("t3_ovr_pulse", 32'(if_m.overrun), 32'd0);
        drain_one(8'h11); drain_one(8'h22); drain_one(8'h33); drain_one(8'h44);
        chk("t3_drained", 32'(if_m.fifo_count), 32'd0);

        // full, ack on the completing cycle
        send_word(8'h81, 1'b0, 1'b0);
        send_word(8'h42, 1'b0, 1'b0);
        send_word(8'h24, 1'b0, 1'b0);
        send_word(8'h18, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b1);
        chk("t4_no_ovr", 32'(if_m.overrun), 32'd0);
        chk("t4_count", 32'(if_m.fifo_count), 32'd4);
        drain_one(8'h42); drain_one(8'h24); drain_one(8'h18); drain_one(8'hC3);

        // resync mid-word
        pat = 8'hA5;
        repeat (3) send_bit(1'b1, 1'b0, 1'b0);
        send_bit(pat[7], 1'b1, 1'b0);
        chk("t5_ferr", 32'(if_m.frame_error), 32'd1);
        send_bit(pat[6], 1'b0, 1'b0);
        chk("t5_ferr_pulse", 32'(if_m.frame_error), 32'd0);
        for (int i = 5; i >= 0; i--) send_bit(pat[i], 1'b0, 1'b0);
        chk("t5_msb", 32'(if_m.parallel_out), 32'hA5);
        chk("t5_lsb", 32'(if_l.parallel_out), 32'hA5);
        chk("t5_count", 32'(if_m.fifo_count), 32'd1);
        drain_one(8'hA5);

        // reset with partial word and queued words
        send_word(8'h01, 1'b0, 1'b0);
        send_word(8'h02, 1'b0, 1'b0);
        repeat (4) send_bit(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_valid", 32'(if_m.parallel_valid), 32'd0);
        chk("t6_out", 32'(if_m.parallel_out), 32'd0);
        chk("t6_count", 32'(if_m.fifo_count), 32'd0);
        pat = 8'h3C;
        send_bit(pat[7], 1'b1, 1'b0);
        chk("t6_idle_fs", 32'(if_m.frame_error), 32'd0);
        for (int i = 6; i >= 0; i--) send_bit(pat[i], 1'b0, 1'b0);
        chk("t6_msb", 32'(if_m.parallel_out), 32'h3C);
        chk("t6_lsb", 32'(if_l.parallel_out), 32'h3C);
        chk("t6_count1", 32'(if_m.fifo_count), 32'd1);
        drain_one(8'h3C);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_deserializer_fifo.md
# spi_deserializer_fifo

Parametrised serial-to-parallel deserializer with an output FIFO, the next generation of the SPI receive FSM. It collects qualified serial bits into PARALLEL_WIDTH-bit words, MSB- or LSB-first, and re-synchronises on a frame marker. Completed words are buffered in a FIFO_DEPTH-entry queue drained through a valid/ack handshake. It sits between the serial front end and the first WiMAX PHY word-oriented stage (randomizer/FEC input).

## Interface
- PARALLEL_WIDTH, 8, word width in bits; ≥2.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.
- MSB_FIRST, 1, 1: first received bit lands in bit [W-1]; 0: first bit lands in bit [0].

Clock and reset: one clock; reset is synchronous and active-high.

- clk  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high; clears all state.
- serial_ready  in  1  serial_in is a valid bit this cycle.
- serial_in  in  1  serial data bit.
- frame_start  in  1  qualified by serial_ready; this bit is bit 0 of a new word.
- parallel_ack  in  1  consumer accepts the head word this cycle.
- parallel_valid  out  1  FIFO non-empty.
- parallel_out  out  PARALLEL_WIDTH  head word of FIFO; all-zero when empty.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words currently held.
- overrun  out  1  one-cycle pulse: completed word dropped, FIFO full.
- frame_error  out  1  one-cycle pulse: frame_start discarded a partial word.

## Operation
- FSM states: S_IDLE (bit_cnt = 0, no partial word), S_SHIFT (1 ≤ bit_cnt ≤ W-1).
- Bit accept: serial_ready = 1 samples serial_in, increments bit_cnt, places bit per MSB_FIRST; S_IDLE→S_SHIFT.
- serial_ready = 0: pause; shift register and bit_cnt hold, no timeout.
- Word complete: bit accepted with bit_cnt = W-1 → assembled word pushed, bit_cnt←0, →S_IDLE.
- frame_start = 1 with serial_ready = 1 in S_SHIFT: partial word discarded, frame_error pulses, current bit becomes bit 0 (bit_cnt←1). In S_IDLE: no error. frame_start without serial_ready is ignored.
- W = 1-bit-left case with frame_start: frame_start wins; no push.
- Push when full: word dropped, overrun pulses, FIFO unchanged; unless a pop occurs the same cycle, then push succeeds (count unchanged, no overrun).
- Pop: parallel_valid && parallel_ack. parallel_ack while empty ignored.
- Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
- Bit order example: bits 0,1,0,1,0,1,0,1, MSB_FIRST=1 → 8'h55; MSB_FIRST=0 → 8'hAA.

## Timing
- Reset: parallel_valid, parallel_out, fifo_count, overrun, frame_error = 0; bit_cnt = 0, S_IDLE, FIFO empty. Reset mid-word or with FIFO content discards everything; the first bit after reset is bit 0.
- Latency: last bit sampled at edge k → parallel_valid = 1 and parallel_out valid after edge k (empty FIFO), i.e. one cycle.
- Pop at edge k → next word (or zeros) visible after edge k; fifo_count updates same edge.
- overrun / frame_error asserted for exactly the cycle after the offending edge.
- Throughput: one bit per clock sustained; one word per W clocks with continuous ack, no loss.

## Structure
- Package spi_deser_pkg: state enum (S_IDLE, S_SHIFT), count-width helper functions.
- Sub-module sync_fifo (PARALLEL_WIDTH × FIFO_DEPTH, push/pop/full/empty/count, simultaneous push+pop when full permitted); assembler FSM in the top.

## Test plan
- Reset, continuous bits 0,1,0,1,0,1,0,1, MSB_FIRST=1 → parallel_valid one cycle after 8th bit, parallel_out = 8'h55, fifo_count = 1; MSB_FIRST=0 → 8'hAA.
- Bits with serial_ready gaps of 1–3 cycles between each → same 8'h55; no extra words.
- parallel_ack = 0, send 5 words (FIFO_DEPTH=4) → fifo_count = 4, overrun pulse once on 5th; draining returns words 1–4 in order.
- FIFO full, ack asserted on the same cycle the 5th word completes → no overrun, count stays 4, 5th word retained.
- 3 bits then frame_start with next bit → frame_error pulse; following 8 bits 8'hA5 → output 8'hA5.
- Reset asserted after 4 bits and with 2 words queued → all outputs 0; next 8 bits produce one correct word.
